// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver.
// Optional feature macro: SR_SKIP_REDUNDANT_EN.
package sr_drv_pkg;

  localparam int   CNT_W     = 8;
  localparam logic CMD_SET   = 1'b1;
  localparam logic CMD_RESET = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    PULSE,
    VERIFY
  } state_t;

endpackage

// File: rtl/sr_timer.sv
// Loadable down-counter shared by the GUARD, PULSE and VERIFY phases.
// Holds at zero instead of wrapping.
module sr_timer
  import sr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of a NOR latch with guard, pulse and verify phases.
// Macro SR_SKIP_REDUNDANT_EN: skip commands the latch already satisfies.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Qn,
  output logic done,
  output logic err,
  output logic value
);

  // Each phase lasts (load value + 1) cycles and ends on the zero flag.
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_target;
  logic             r_s;
  logic             r_r;
  logic             r_done;
  logic             r_err;
  logic             r_value;

  state_t           w_next;
  logic             w_target;
  logic             w_s;
  logic             w_r;
  logic             w_done;
  logic             w_err;
  logic             w_value;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_zero;
  logic             w_match;
  logic             w_skip;

  sr_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .o_zero (w_zero)
  );

  assign w_match = (Q == r_target) && (Qn == ~r_target);

`ifdef SR_SKIP_REDUNDANT_EN
  assign w_skip = (Q == cmd_set) && (Qn == ~cmd_set);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_target = r_target;
    w_s      = 1'b0;
    w_r      = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_value  = r_value;
    w_load   = 1'b0;
    w_ld_val = '0;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_target = cmd_set;
          if (w_skip) begin
            w_done  = 1'b1;
            w_value = cmd_set;
          end else if (GAP_W == 0) begin
            w_next   = PULSE;
            w_load   = 1'b1;
            w_ld_val = PULSE_LD;
            w_s      = cmd_set;
            w_r      = ~cmd_set;
          end else begin
            w_next   = GUARD;
            w_load   = 1'b1;
            w_ld_val = GAP_LD;
          end
        end
      end
      GUARD: begin
        if (w_zero) begin
          w_next   = PULSE;
          w_load   = 1'b1;
          w_ld_val = PULSE_LD;
          w_s      = r_target;
          w_r      = ~r_target;
        end
      end
      PULSE: begin
        if (w_zero) begin
          w_next   = VERIFY;
          w_load   = 1'b1;
          w_ld_val = TO_LD;
        end else begin
          w_s = r_target;
          w_r = ~r_target;
        end
      end
      VERIFY: begin
        if (w_match) begin
          w_next  = IDLE;
          w_done  = 1'b1;
          w_value = r_target;
        end else if (w_zero) begin
          w_next = IDLE;
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_target <= 1'b0;
      r_s      <= 1'b0;
      r_r      <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_value  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_target <= w_target;
      r_s      <= w_s;
      r_r      <= w_r;
      r_done   <= w_done;
      r_err    <= w_err;
      r_value  <= w_value;
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign S         = r_s;
  assign R         = r_r;
  assign done      = r_done;
  assign err       = r_err;
  assign value     = r_value;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized self-checking bench for sr_latch_driver with a NOR latch model.
// Honours SR_SKIP_REDUNDANT_EN when the build defines it.
module tb_sr_latch_driver;

  localparam int PW = 2;
  localparam int GW = 1;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_set = 1'b0;
  logic cmd_ready, S, R, done, err, value;
  logic Q, Qn;

  logic lq = 1'b0;
  logic stuck = 1'b0;
  logic sq = 1'b0;
  logic sqn = 1'b0;

  int checks = 0;
  int errors = 0;

  logic m_q = 1'b0;
  logic m_value = 1'b0;

  sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .S(S), .R(R), .Q(Q), .Qn(Qn),
    .done(done), .err(err), .value(value)
  );

  always #5 clk = ~clk;

  always @(S or R) begin
    if (S && !R) lq = 1'b1;
    else if (R && !S) lq = 1'b0;
  end

  assign Q  = stuck ? sq  : lq;
  assign Qn = stuck ? sqn : ~lq;

  // Expected outcome of one command from the behavioural rules.
  task automatic model(input logic set, input logic stk,
                       output int es, output int er,
                       output int ed, output logic ee);
    bit skip;
    skip = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
    skip = !stk && (m_q == set);
`endif
    if (skip) begin
      es = 0; er = 0; ed = 0; ee = 1'b0;
      m_value = set;
    end else begin
      es = set ? PW : 0;
      er = set ? 0 : PW;
      ed = GW + PW + (stk ? TO : 1);
      ee = stk;
      m_q = set;
      if (!stk) m_value = set;
    end
  endtask

  // Issue one command from a negedge in IDLE; returns in the done cycle.
  task automatic run_cmd(input logic set, input logic hold,
                         output int s_cnt, output int r_cnt,
                         output int done_at, output logic err_seen,
                         output int both);
    s_cnt = 0; r_cnt = 0; done_at = -1; err_seen = 1'b0; both = 0;
    cmd_valid = 1'b1;
    cmd_set = set;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (S) s_cnt++;
      if (R) r_cnt++;
      if (S && R) both++;
      if (done) begin
        done_at = j;
        err_seen = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    m_value = 1'b0;
    checks++;
    if ({S, R, done, err, value, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset: got SRdev_rdy=%b want 000001",
               {S, R, done, err, value, cmd_ready});
    end
  endtask

  task automatic test_set_reset;
    int s, r, d, b, es, er, ed;
    logic e, ee;
    logic [33:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      logic st;
      st = (i == 0);
      model(st, 1'b0, es, er, ed, ee);
      run_cmd(st, 1'b0, s, r, d, e, b);
      got = {8'(s), 8'(r), 8'(d), e, value, 8'(b)};
      exp = {8'(es), 8'(er), 8'(ed), ee, m_value, 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL set_reset[%0d]: got %h want %h", i, got, exp);
      end
      checks++;
      if ({Q, Qn} !== {st, ~st}) begin
        errors++;
        $display("FAIL latch_state[%0d]: got %b want %b", i, {Q, Qn}, {st, ~st});
      end
    end
  endtask

  task automatic test_timeout;
    int s, r, d, b, es, er, ed;
    logic e, ee;
    logic [33:0] got, exp;
    stuck = 1'b1; sq = 1'b0; sqn = 1'b1;
    model(1'b1, 1'b1, es, er, ed, ee);
    run_cmd(1'b1, 1'b0, s, r, d, e, b);
    stuck = 1'b0;
    got = {8'(s), 8'(r), 8'(d), e, value, 8'(b)};
    exp = {8'(es), 8'(er), 8'(ed), ee, m_value, 8'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL timeout: got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_pulse;
    logic st, hold_q;
    int late_done;
    st = ~m_q;
    cmd_valid = 1'b1;
    cmd_set = st;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (GW) @(posedge clk);
    #1;
    checks++;
    if ({S, R} !== {st, ~st}) begin
      errors++;
      $display("FAIL mid_pulse_drive: got %b want %b", {S, R}, {st, ~st});
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_q = st;
    m_value = 1'b0;
    hold_q = Q;
    @(negedge clk);
    checks++;
    if ({S, R, done, err, value, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_pulse_reset: got %b want 000001",
               {S, R, done, err, value, cmd_ready});
    end
    late_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || S || R) late_done++;
    end
    checks++;
    if (late_done !== 0 || Q !== hold_q) begin
      errors++;
      $display("FAIL mid_pulse_drop: activity=%0d Q=%b want 0 and Q=%b",
               late_done, Q, hold_q);
    end
  endtask

  task automatic test_back_to_back;
    int s, r, d, b, es, er, ed;
    logic e, ee, st;
    logic [34:0] got, exp;
    st = ~m_q;
    for (int i = 0; i < 6; i++) begin
      model(st, 1'b0, es, er, ed, ee);
      run_cmd(st, 1'b1, s, r, d, e, b);
      got = {8'(s), 8'(r), 8'(d), e, value, 8'(b), cmd_ready};
      exp = {8'(es), 8'(er), 8'(ed), ee, m_value, 8'd0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, got, exp);
      end
      st = ~st;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_skip_redundant;
    int s, r, d, b, es, er, ed;
    logic e, ee, st;
    logic [33:0] got, exp;
    st = m_q;
    model(st, 1'b0, es, er, ed, ee);
    run_cmd(st, 1'b0, s, r, d, e, b);
    got = {8'(s), 8'(r), 8'(d), e, value, 8'(b)};
    exp = {8'(es), 8'(er), 8'(ed), ee, m_value, 8'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL skip_redundant: got %h want %h", got, exp);
    end
  endtask

  task automatic test_random;
    int s, r, d, b, es, er, ed;
    logic e, ee, st, stk;
    logic [33:0] got, exp;
    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      stk = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (stk) begin
        case ($urandom_range(0, 2))
          0:       begin sq = ~st;  sqn = st;   end
          1:       begin sq = 1'b0; sqn = 1'b0; end
          default: begin sq = 1'b1; sqn = 1'b1; end
        endcase
        stuck = 1'b1;
      end
      model(st, stk, es, er, ed, ee);
      run_cmd(st, 1'b0, s, r, d, e, b);
      stuck = 1'b0;
      got = {8'(s), 8'(r), 8'(d), e, value, 8'(b)};
      exp = {8'(es), 8'(er), 8'(ed), ee, m_value, 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] set=%b stuck=%b: got %h want %h",
                 i, st, stk, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_timeout();
    test_reset_mid_pulse();
    test_skip_redundant();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous controller that drives the active-high S/R inputs of a NOR SR latch and reads back its Q/Qn outputs.
- Accepts set/reset commands over a valid/ready handshake.
- Per command: a dead-time guard, a fixed-width S or R pulse, then verification that the latch reached the commanded state within a timeout.
- Sits between synchronous control logic and an asynchronous storage latch. S and R are never asserted together.

Parameters:
- PULSE_W, 2, cycles S or R is held high per command; must be 1..255.
- GAP_W, 1, guard cycles with S=R=0 before each pulse; must be 0..255 (0 skips GUARD).
- TIMEOUT, 8, maximum VERIFY cycles before error; must be 1..255.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_set  input  1  1 = set latch (Q=1), 0 = reset latch (Q=0)
- cmd_ready  output  1  driver can accept a command
- S  output  1  latch set input, active-high
- R  output  1  latch reset input, active-high
- Q  input  1  latch Q readback
- Qn  input  1  latch Qn readback
- done  output  1  one-cycle pulse: command finished
- err  output  1  one-cycle pulse with done: verify timeout
- value  output  1  last successfully verified latch value

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high; it takes effect on the rising edge of clk.
  - On reset: state=IDLE, S=0, R=0, done=0, err=0, value=0, counters cleared.
- Reset mid-operation: S and R fall at the next edge and the in-flight command is dropped with no done. The latch keeps its value.
- Outputs: S, R, done, err and value are registered. cmd_ready = (state==IDLE), combinational from state.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_set is captured into target. Inputs are ignored while not IDLE.
- FSM states: IDLE, GUARD, PULSE, VERIFY.
- IDLE:
  - On accept: go to GUARD, loading GAP_W.
  - If GAP_W=0, go straight to PULSE, loading PULSE_W.
- GUARD: S=R=0 for GAP_W cycles, then PULSE.
- PULSE:
  - S=target and R=~target for exactly PULSE_W cycles.
  - Then VERIFY, loading TIMEOUT.
- VERIFY:
  - S=R=0.
  - Each cycle sample Q,Qn.
  - Match (Q==target && Qn==~target): next edge go to IDLE with done=1, err=0, value=target.
  - No match on the TIMEOUT-th VERIFY cycle: go to IDLE with done=1, err=1; value unchanged.
- done/err timing: high for exactly one cycle, coinciding with the first IDLE cycle. A new command may be accepted in that same cycle.
- Latency (defaults, latch responding within the pulse):
  - Accept at edge k.
  - GUARD in cycle k+1.
  - S high in cycles k+2..k+3.
  - VERIFY in k+4.
  - done at k+5.
- Invariant: S && R is never 1.
- Invalid readback: Q==Qn counts as a mismatch.
- Counters: 8-bit down-counters, no wrap. Parameter values outside their ranges are illegal.

Optional Feature:
- Macro: SR_SKIP_REDUNDANT_EN.
- Defined: on accept, if Q==cmd_set && Qn==~cmd_set, no GUARD or PULSE is issued. The FSM stays in IDLE; done=1, err=0, value=cmd_set on the next cycle (latency 1).
- Undefined: every command runs the full GUARD/PULSE/VERIFY sequence regardless of the current latch state.

Decomposition:
- Package sr_drv_pkg:
  - state enum (IDLE, GUARD, PULSE, VERIFY);
  - CMD_SET=1, CMD_RESET=0;
  - CNT_W=8.
- Sub-module sr_timer:
  - loadable 8-bit down-counter with load, load value and zero flag;
  - a single instance is shared by GUARD, PULSE and VERIFY.

Test Plan:
- Reset, then set: rst high 2 cycles -> S=R=0, value=0, cmd_ready=1. cmd_set=1 accepted at k -> S=1 in k+2..k+3, done=1 and err=0 at k+5, value=1, Q=1.
- Reset command: after the set, cmd_set=0 -> R=1 for 2 cycles, S stays 0, done at +5, value=0, Q=0, Qn=1.
- Timeout: force Q=0, Qn=1 stuck, command set -> 8 VERIFY cycles, then done=1 and err=1 at k+12, value unchanged.
- Reset mid-pulse: rst asserted during the first PULSE cycle -> S=0 next edge, no done, cmd_ready=1, latch holds its prior Q.
- Back-to-back: cmd_valid held high with alternating cmd_set -> each new accept occurs in the done cycle, and S&&R==0 on every cycle (assertion).
- With SR_SKIP_REDUNDANT_EN: latch already Q=1, command set -> done=1 at k+1, no S pulse. Without the macro: full 5-cycle sequence with an S pulse.
